// File: rtl/div_pkg.sv
// Shared types and default widths for the signed divide front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int DIV_DIVIDEND_WIDTH = 64;
  localparam int DIV_DIVISOR_WIDTH  = 32;
  localparam int DIV_FIFO_DEPTH     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_fifo.sv
// Synchronous operand FIFO, power-of-two depth, first-word-fall-through head.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module div_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop may both happen in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/div_feeder.sv
// Signed front-end for an unsigned shift divider: buffers operands, feeds magnitudes, sign-corrects results.
// Latency: pop-to-issue 1 cycle, result in HOLD the cycle after div_valid_out; one request outstanding.
// Backpressure: in_ready = FIFO not full; result held in HOLD until out_ready. DIV_FEEDER_SAT_EN enables saturation.
module div_feeder
  import div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIV_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DIV_DIVISOR_WIDTH,
  parameter int FIFO_DEPTH     = DIV_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
  input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] out_quotient,
  output logic [DIVISOR_WIDTH-1:0]  out_remainder,
  output logic                      out_dbz,
  output logic                      div_valid_in,
  output logic [DIVIDEND_WIDTH-1:0] div_dividend,
  output logic [DIVISOR_WIDTH-1:0]  div_divisor,
  input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
  input  logic [DIVISOR_WIDTH-1:0]  div_remainder,
  input  logic                      div_valid_out,
  input  logic                      div_overflow
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int FW = DW + VW;

`ifdef DIV_FEEDER_SAT_EN
  localparam logic [DW-1:0] Q_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [VW-1:0] DIV_ONE = 1;
`endif

  div_state_t      state, state_nxt;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]   fifo_head;
  logic [DW-1:0]   head_dividend;
  logic [VW-1:0]   head_divisor;
  logic            sign_a, sign_b, dbz;
  logic [DW-1:0]   mag_a;
  logic [VW-1:0]   mag_b;
  logic            capture, dbz_now;
  logic [DW-1:0]   res_q, out_q;
  logic [VW-1:0]   res_r, out_r;
  logic            out_dbz_r;

  div_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data ({in_dividend, in_divisor}),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty)
  );

  assign in_ready      = !fifo_full;
  assign head_dividend = fifo_head[FW-1:VW];
  assign head_divisor  = fifo_head[VW-1:0];
  assign div_dividend  = mag_a;
  assign div_divisor   = mag_b;
  assign out_quotient  = out_q;
  assign out_remainder = out_r;
  assign dbz_now       = dbz | div_overflow;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: pop, issue one request, wait for the divider, hold the result.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty)   state_nxt = ST_ISSUE;
      ST_ISSUE:                    state_nxt = ST_WAIT;
      ST_WAIT:  if (div_valid_out) state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready)     state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; a divider response outside WAIT (e.g. after a reset) is ignored.
  always_comb begin
    fifo_pop     = (state == ST_IDLE) && !fifo_empty;
    div_valid_in = (state == ST_ISSUE);
    out_valid    = (state == ST_HOLD);
    capture      = (state == ST_WAIT) && div_valid_out;
    out_dbz      = (state == ST_HOLD) && out_dbz_r;
  end

  // Sign-correct the unsigned response: quotient negative on differing signs, remainder follows dividend.
  always_comb begin
    res_q = (sign_a ^ sign_b) ? -div_quotient : div_quotient;
    res_r = sign_a ? -div_remainder : div_remainder;
`ifdef DIV_FEEDER_SAT_EN
    if (dbz_now) begin
      res_q = sign_a ? Q_MIN : Q_MAX;
      res_r = '0;
    end else if (sign_a && sign_b && (mag_a == Q_MIN) && (mag_b == DIV_ONE)) begin
      res_q = Q_MAX;
    end
`endif
  end

  // Operand magnitudes held from pop until the next pop; the negation of the most-negative value wraps to 2^(W-1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      dbz       <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dbz_r <= 1'b0;
    end else begin
      if (fifo_pop) begin
        sign_a <= head_dividend[DW-1];
        sign_b <= head_divisor[VW-1];
        mag_a  <= head_dividend[DW-1] ? -head_dividend : head_dividend;
        mag_b  <= head_divisor[VW-1]  ? -head_divisor  : head_divisor;
        dbz    <= (head_divisor == '0);
      end else if ((state == ST_WAIT) && div_overflow) begin
        dbz <= 1'b1;
      end
      if (capture) begin
        out_q     <= res_q;
        out_r     <= res_r;
        out_dbz_r <= dbz_now;
      end
    end
  end

endmodule

// File: tb/tb_div_feeder.sv
// Bench for div_feeder with a behavioural unsigned divider and an expected-result scoreboard.
// Latency: divider model answers 2..7 cycles after div_valid_in.
// Backpressure: out_ready driven by the stimulus to exercise FIFO fill and HOLD.
module tb_div_feeder;

  localparam int DW = 64;
  localparam int VW = 32;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_dividend;
  logic [VW-1:0] in_divisor;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_quotient;
  logic [VW-1:0] out_remainder;
  logic          out_dbz;
  logic          div_valid_in;
  logic [DW-1:0] div_dividend;
  logic [VW-1:0] div_divisor;
  logic [DW-1:0] div_quotient = '0;
  logic [VW-1:0] div_remainder = '0;
  logic          div_valid_out = 1'b0;
  logic          div_overflow = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  div_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dbz       (out_dbz),
    .div_valid_in  (div_valid_in),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_valid_out (div_valid_out),
    .div_overflow  (div_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Unsigned divider stand-in; never reset by the feeder, so a stale answer can follow a reset.
  logic        busy = 1'b0;
  logic        stale = 1'b0;
  int          cnt = 0;
  logic [63:0] cap_a = '0;
  logic [31:0] cap_b = '0;
  logic [63:0] tmp_q;
  always @(posedge clk) begin
    div_valid_out <= 1'b0;
    div_overflow  <= 1'b0;
    if (busy) begin
      div_overflow <= (cap_b == 0);
      if (cnt == 0) begin
        busy          <= 1'b0;
        div_valid_out <= 1'b1;
        if (cap_b == 0) begin
          div_quotient  <= '1;
          div_remainder <= cap_a[31:0];
        end else begin
          tmp_q = cap_a % {32'd0, cap_b};
          div_quotient  <= cap_a / {32'd0, cap_b};
          div_remainder <= tmp_q[31:0];
        end
        if (!stale) begin
          chk("div_hold_dividend", div_dividend, cap_a);
          chk("div_hold_divisor", {32'd0, div_divisor}, {32'd0, cap_b});
        end
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (!reset) stale <= 1'b1;
    else if (div_valid_in) stale <= 1'b0;
    if (div_valid_in) begin
      busy  <= 1'b1;
      cap_a <= div_dividend;
      cap_b <= div_divisor;
      cnt   <= $urandom_range(1, 6);
    end
  end

  // Result monitor: sampled well after the negedge when every bench input has settled.
  always @(negedge clk) begin
    #2;
    if (reset && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", out_quotient, mon_e.q);
        chk("remainder", {32'd0, out_remainder}, {32'd0, mon_e.r});
        chk("dbz", {63'd0, out_dbz}, {63'd0, mon_e.dbz});
      end
    end
  end

  // Reference for random operands: native signed division truncates toward zero.
  function automatic exp_t model(input logic signed [63:0] a, input logic signed [31:0] b);
    exp_t              e;
    logic signed [63:0] bb;
    logic signed [63:0] rr;
    logic [63:0]       ua;
    logic [31:0]       rm;
    bb    = b;
    e.dbz = (b == 0);
    e.r   = '0;
    if (b == 0) begin
`ifdef DIV_FEEDER_SAT_EN
      e.q = a[63] ? MIN64 : MAX64;
`else
      ua  = a[63] ? -a : a;
      rm  = ua[31:0];
      e.q = a[63] ? 64'd1 : '1;
      e.r = a[63] ? -rm : rm;
`endif
    end else if (a == MIN64 && b == -1) begin
`ifdef DIV_FEEDER_SAT_EN
      e.q = MAX64;
`else
      e.q = MIN64;
`endif
    end else begin
      e.q = a / bb;
      rr  = a % bb;
      e.r = rr[31:0];
    end
    return e;
  endfunction

  // Drive one operand pair starting at a negedge; returns the stall cycles seen.
  task automatic send(input logic [63:0] a, input logic [31:0] b, input exp_t e, output int stalls);
    stalls      = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    while (!in_ready && stalls < 300) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 300) chk("send_timeout", 64'd1, 64'd0);
    else sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [63:0] a, input logic [31:0] b,
                          input logic [63:0] q, input logic [31:0] r, input logic dbz);
    exp_t e;
    int   s;
    e.q = q; e.r = r; e.dbz = dbz;
    send(a, b, e, s);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  logic signed [63:0] ra;
  logic signed [31:0] rb;
  int                 st;
  int                 n_mark;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_div_valid_in", {63'd0, div_valid_in}, 64'd0);
    chk("rst_out_dbz", {63'd0, out_dbz}, 64'd0);
    chk("rst_out_quotient", out_quotient, 64'd0);
    chk("rst_div_dividend", div_dividend, 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived results.
    send_exp(64'd100, 32'd7, 64'd14, 32'd2, 1'b0);
    send_exp(-64'sd100, 32'd7, -64'sd14, -32'sd2, 1'b0);
    send_exp(64'd100, -32'sd7, -64'sd14, 32'd2, 1'b0);
    send_exp(-64'sd100, -32'sd7, 64'd14, -32'sd2, 1'b0);
    send_exp(64'd7, 32'd100, 64'd0, 32'd7, 1'b0);
    send_exp(MIN64, 32'd1, MIN64, 32'd0, 1'b0);
    send_exp(MIN64, 32'h8000_0000, 64'h1_0000_0000, 32'd0, 1'b0);
    send_exp(-64'sd1, 32'h8000_0000, 64'd0, 32'hFFFF_FFFF, 1'b0);
`ifdef DIV_FEEDER_SAT_EN
    send_exp(64'd5, 32'd0, MAX64, 32'd0, 1'b1);
    send_exp(-64'sd5, 32'd0, MIN64, 32'd0, 1'b1);
    send_exp(MIN64, -32'sd1, MAX64, 32'd0, 1'b0);
`else
    send_exp(64'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 1'b1);
    send_exp(-64'sd5, 32'd0, 64'd1, 32'hFFFF_FFFB, 1'b1);
    send_exp(MIN64, -32'sd1, MIN64, 32'd0, 1'b0);
`endif
    drain();

    // Random operands across magnitudes, with occasional zero divisors.
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      ra = ra >>> $urandom_range(0, 60);
      rb = $urandom;
      rb = rb >>> $urandom_range(0, 31);
      if (i % 10 == 3) rb = '0;
      send(ra, rb, model(ra, rb), st);
      if (i % 7 == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        out_ready = 1'b1;
      end
    end
    drain();

    // Five back-to-back pushes with the output stalled: four buffered plus one in flight.
    n_mark = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = 64'd1000 + 64'(i * 37);
      rb = 32'(i + 3);
      send(ra, rb, model(ra, rb), st);
      chk("bp_no_stall", 64'(st), 64'd0);
    end
    chk("bp_full", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_dividend = 64'd999; in_divisor = 32'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stays_full", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    st = 0;
    while (!out_valid && st < 200) begin
      @(negedge clk);
      st++;
    end
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_quotient", out_quotient, sb[0].q);
    end
    out_ready = 1'b1;
    drain();
    chk("bp_count", 64'(n_out - n_mark), 64'd5);

    // Reset while the divider is busy: buffered and outstanding work must vanish.
    out_ready = 1'b1;
    send_exp(64'd77, 32'd5, 64'd15, 32'd2, 1'b0);
    st = 0;
    while (!div_valid_in && st < 50) begin
      @(negedge clk);
      st++;
    end
    chk("rst_test_issue", {63'd0, div_valid_in}, 64'd1);
    send_exp(64'd88, 32'd3, 64'd29, 32'd1, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_div_valid_in", {63'd0, div_valid_in}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_mark = n_out;
    repeat (20) @(negedge clk);
    chk("no_stale_result", 64'(n_out - n_mark), 64'd0);
    send_exp(64'd100, 32'd7, 64'd14, 32'd2, 1'b0);
    drain();
    chk("post_rst_count", 64'(n_out - n_mark), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_feeder.md
DIV_FEEDER -- requirements
Module: div_feeder

Interface
REQ-001 Parameter DIVIDEND_WIDTH, default 64, dividend and quotient width (two's complement).
REQ-002 Parameter DIVISOR_WIDTH, default 32, divisor and remainder width (two's complement).
REQ-003 Parameter FIFO_DEPTH, default 4, input operand buffer depth (power of two, at least 2).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-006 in_valid/in_ready  in/out  1/1  upstream operand handshake.
REQ-007 in_dividend/in_divisor  in  DIVIDEND_WIDTH/DIVISOR_WIDTH  signed operands.
REQ-008 out_valid/out_ready  out/in  1/1  downstream result handshake.
REQ-009 out_quotient/out_remainder  out  DIVIDEND_WIDTH/DIVISOR_WIDTH  signed results.
REQ-010 out_dbz  out  1  divide-by-zero flag, qualified by out_valid.
REQ-011 div_valid_in, div_dividend, div_divisor  out  1/DIVIDEND_WIDTH/DIVISOR_WIDTH  request to the unsigned shift divider.
REQ-012 div_quotient, div_remainder, div_valid_out, div_overflow  in  DIVIDEND_WIDTH/DIVISOR_WIDTH/1/1  divider response.

Function
REQ-013 A transfer is in_valid && in_ready on a rising edge; in_ready SHALL equal not-FIFO-full, independent of in_valid.
REQ-014 Push and pop in the same cycle on a non-empty, non-full FIFO SHALL both occur; occupancy is unchanged.
REQ-015 Push with in_ready low SHALL be ignored; operands are not overwritten.
REQ-016 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-017 IDLE, FIFO non-empty: pop the head; register sign bits and unsigned magnitudes; go to ISSUE.
REQ-018 ISSUE: drive div_valid_in high for exactly one cycle; go to WAIT.
REQ-019 div_dividend and div_divisor SHALL hold the magnitudes stable from ISSUE until the cycle after div_valid_out.
REQ-020 WAIT: any cycle with div_overflow high SHALL set a sticky dbz bit.
REQ-021 WAIT: on div_valid_out, capture div_quotient and div_remainder, apply signs, and go to HOLD.
REQ-022 dbz SHALL also be set locally when the popped divisor is 0.
REQ-023 Sign rule: truncation toward zero.
REQ-024 Quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
REQ-025 Magnitude of the most-negative operand SHALL be 2^(W-1) as unsigned, with no error.
REQ-026 HOLD: out_valid is high; outputs SHALL remain stable until out_ready.
REQ-027 HOLD with out_ready high: go to IDLE; the next pop is no earlier than the following cycle.
REQ-028 Only one request is outstanding at a time; the FIFO keeps accepting while the FSM is busy.
REQ-029 WAIT has no timeout; the divider always completes.

Reset
REQ-030 During reset: FSM in IDLE; FIFO empty; in_ready 1; out_valid, out_dbz, div_valid_in 0; data outputs 0.
REQ-031 Reset mid-operation SHALL discard the outstanding request and all buffered operands.
REQ-032 The divider's reset is driven externally; div_feeder SHALL NOT reset it.

Configuration
REQ-033 DIV_FEEDER_SAT_EN defined, divide-by-zero: out_quotient saturates to max positive (dividend >= 0) or min negative (dividend < 0); out_remainder is 0.
REQ-034 DIV_FEEDER_SAT_EN defined, min-negative dividend divided by -1: out_quotient is max positive.
REQ-035 DIV_FEEDER_SAT_EN undefined: the sign-corrected divider result passes raw and wraps two's complement; out_dbz is still reported.

Structure
REQ-036 Package div_pkg SHALL hold the FSM state enum and default width constants.
REQ-037 Sub-module div_fifo (synchronous FIFO, same clk/reset) SHALL implement the operand buffer.

Verification
REQ-038 100 / 7 -> quotient 14, remainder 2, dbz 0.
REQ-039 -100 / 7 -> quotient -14, remainder -2.
REQ-040 100 / -7 -> quotient -14, remainder 2.
REQ-041 5 / 0 -> dbz 1; with SAT_EN, quotient 0x7FFF_FFFF_FFFF_FFFF and remainder 0.
REQ-042 Min-negative dividend / -1 -> SAT_EN quotient 0x7FFF_FFFF_FFFF_FFFF; without, 0x8000_0000_0000_0000.
REQ-043 Push 5 pairs back-to-back with out_ready held 0 -> in_ready drops after 4 buffered plus 1 in flight; release gives 5 in-order results.
REQ-044 Assert reset in WAIT -> out_valid 0 and in_ready 1 immediately; no stale result after release.
